uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: x16 oversampled, centre-of-bit sampling, LSB-first framing,
// with a held-data register, sticky overrun flag and framing-error pulse.
module uart_rx #(
   parameter int P_DATA_BITS = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   TICK16,
   input  logic                   RX,
   input  logic                   DATA_ACK,
   output logic [P_DATA_BITS-1:0] DATA,
   output logic                   VALID,
   output logic                   OVERRUN,
   output logic                   FRAME_ERR,
   output logic                   BUSY
);

   localparam int IDX_W = (P_DATA_BITS > 1) ? $clog2(P_DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_e;

   logic                   rx_meta_q;
   logic                   rx_s_q;
   state_e                 state_q,   state_d;
   logic [3:0]             cnt_q,     cnt_d;
   logic [IDX_W-1:0]       idx_q,     idx_d;
   logic [P_DATA_BITS-1:0] shift_q,   shift_d;
   logic [P_DATA_BITS-1:0] data_q,    data_d;
   logic                   valid_q,   valid_d;
   logic                   overrun_q, overrun_d;
   logic                   ferr_q,    ferr_d;

   // Synchronizer resets to the idle (high) line level so reset never looks like a start edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      ferr_d    = 1'b0;

      if (DATA_ACK) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      if (TICK16) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  state_d = ST_START;
                  cnt_d   = 4'd0;
               end
            end

            // Half a bit into the start bit: a line that went high again was a glitch.
            ST_START: begin
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (!rx_s_q) begin
                     state_d = ST_DATA;
                     idx_d   = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end

            ST_DATA: begin
               if (cnt_q == 4'd15) begin
                  cnt_d   = 4'd0;
                  shift_d = {rx_s_q, shift_q[P_DATA_BITS-1:1]};
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end

            // A good stop while an unacknowledged word is held overwrites it and flags overrun.
            ST_STOP: begin
               if (cnt_q == 4'd15) begin
                  cnt_d = 4'd0;
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     if (valid_q && !DATA_ACK) begin
                        overrun_d = 1'b1;
                     end
                  end else begin
                     state_d = ST_BREAK;
                     ferr_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end

            ST_BREAK: begin
               if (rx_s_q) begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign OVERRUN   = overrun_q;
   assign FRAME_ERR = ferr_q;
   assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames driven at 16 ticks per bit, tick every 4 clocks.
module tb_uart_rx;

   logic       CLK;
   logic       RST;
   logic       TICK16;
   logic       RX;
   logic       DATA_ACK;
   logic [7:0] DATA;
   logic       VALID;
   logic       OVERRUN;
   logic       FRAME_ERR;
   logic       BUSY;

   int vecCount   = 0;
   int missCount  = 0;
   int ferrPulses = 0;
   int ferrCycles = 0;
   logic ferrPrev = 1'b0;
   int divCnt     = 0;

   uart_rx #(.P_DATA_BITS(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .TICK16    (TICK16),
      .RX        (RX),
      .DATA_ACK  (DATA_ACK),
      .DATA      (DATA),
      .VALID     (VALID),
      .OVERRUN   (OVERRUN),
      .FRAME_ERR (FRAME_ERR),
      .BUSY      (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // One-cycle tick every fourth clock, changed on the falling edge.
   initial begin
      TICK16 = 1'b0;
      forever begin
         @(negedge CLK);
         divCnt = (divCnt + 1) % 4;
         TICK16 = (divCnt == 0);
      end
   end

   // Counts framing-error pulses and the total cycles FRAME_ERR is high.
   initial begin
      forever begin
         @(negedge CLK);
         if (FRAME_ERR === 1'b1) begin
            ferrCycles++;
            if (ferrPrev !== 1'b1) ferrPulses++;
         end
         ferrPrev = FRAME_ERR;
      end
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge CLK); while (TICK16 !== 1'b1);
         #1;
      end
   endtask

   task automatic driveBits(input logic [7:0] value);
      for (int i = 0; i < 8; i++) begin
         RX = value[i];
         waitTicks(16);
      end
   endtask

   task automatic sendFrame(input logic [7:0] value);
      waitTicks(1);
      RX = 1'b0;
      waitTicks(16);
      driveBits(value);
      RX = 1'b1;
      waitTicks(16);
   endtask

   task automatic pulseAck();
      @(negedge CLK);
      DATA_ACK = 1'b1;
      @(negedge CLK);
      DATA_ACK = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (5) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      vecCount++; if (DATA !== 8'h00) begin $display("[TB] FAIL reset_data: got %h expected 00", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL reset_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (OVERRUN !== 1'b0) begin $display("[TB] FAIL reset_overrun: got %b expected 0", OVERRUN); missCount++; end
      vecCount++; if (FRAME_ERR !== 1'b0) begin $display("[TB] FAIL reset_frame_err: got %b expected 0", FRAME_ERR); missCount++; end
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); missCount++; end
   endtask

   task automatic test_frame_55();
      int base;
      base = ferrPulses;
      sendFrame(8'h55);
      vecCount++; if (DATA !== 8'h55) begin $display("[TB] FAIL f55_data: got %h expected 55", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL f55_valid: got %b expected 1", VALID); missCount++; end
      vecCount++; if (OVERRUN !== 1'b0) begin $display("[TB] FAIL f55_overrun: got %b expected 0", OVERRUN); missCount++; end
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL f55_busy: got %b expected 0", BUSY); missCount++; end
      vecCount++; if (ferrPulses != base) begin $display("[TB] FAIL f55_no_ferr: got %0d pulses expected 0", ferrPulses - base); missCount++; end
      pulseAck();
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL f55_ack_valid: got %b expected 0", VALID); missCount++; end
   endtask

   task automatic test_glitch();
      waitTicks(1);
      RX = 1'b0;
      waitTicks(3);
      vecCount++; if (BUSY !== 1'b1) begin $display("[TB] FAIL glitch_busy_high: got %b expected 1", BUSY); missCount++; end
      waitTicks(1);
      RX = 1'b1;
      waitTicks(10);
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL glitch_busy_low: got %b expected 0", BUSY); missCount++; end
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL glitch_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (DATA !== 8'h55) begin $display("[TB] FAIL glitch_data: got %h expected 55", DATA); missCount++; end
   endtask

   task automatic test_frame_error();
      int base;
      int baseCycles;
      base = ferrPulses;
      baseCycles = ferrCycles;
      waitTicks(1);
      RX = 1'b0;
      waitTicks(16);
      driveBits(8'hA3);
      RX = 1'b0;
      waitTicks(16 + 40);
      vecCount++; if (ferrPulses - base != 1) begin $display("[TB] FAIL ferr_pulses: got %0d expected 1", ferrPulses - base); missCount++; end
      vecCount++; if (ferrCycles - baseCycles != 1) begin $display("[TB] FAIL ferr_width: got %0d cycles expected 1", ferrCycles - baseCycles); missCount++; end
      vecCount++; if (DATA !== 8'h55) begin $display("[TB] FAIL ferr_data_kept: got %h expected 55", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL ferr_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (BUSY !== 1'b1) begin $display("[TB] FAIL ferr_break_busy: got %b expected 1", BUSY); missCount++; end
      RX = 1'b1;
      waitTicks(2);
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL ferr_break_exit: got %b expected 0", BUSY); missCount++; end
      sendFrame(8'h3C);
      vecCount++; if (DATA !== 8'h3C) begin $display("[TB] FAIL ferr_next_data: got %h expected 3c", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL ferr_next_valid: got %b expected 1", VALID); missCount++; end
      vecCount++; if (ferrPulses - base != 1) begin $display("[TB] FAIL ferr_next_no_ferr: got %0d pulses expected 1", ferrPulses - base); missCount++; end
      pulseAck();
   endtask

   task automatic test_back_to_back();
      sendFrame(8'h11);
      vecCount++; if (DATA !== 8'h11) begin $display("[TB] FAIL b2b_first_data: got %h expected 11", DATA); missCount++; end
      vecCount++; if (OVERRUN !== 1'b0) begin $display("[TB] FAIL b2b_first_overrun: got %b expected 0", OVERRUN); missCount++; end
      sendFrame(8'h22);
      vecCount++; if (DATA !== 8'h22) begin $display("[TB] FAIL b2b_data: got %h expected 22", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL b2b_valid: got %b expected 1", VALID); missCount++; end
      vecCount++; if (OVERRUN !== 1'b1) begin $display("[TB] FAIL b2b_overrun: got %b expected 1", OVERRUN); missCount++; end
      pulseAck();
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL b2b_ack_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (OVERRUN !== 1'b0) begin $display("[TB] FAIL b2b_ack_overrun: got %b expected 0", OVERRUN); missCount++; end
   endtask

   task automatic test_reset_midframe();
      int base;
      base = ferrPulses;
      waitTicks(1);
      RX = 1'b0;
      waitTicks(16);
      for (int i = 0; i < 4; i++) begin
         RX = 1'b1;
         waitTicks(16);
      end
      RX = 1'b1;
      waitTicks(8);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL rstmid_busy: got %b expected 0", BUSY); missCount++; end
      vecCount++; if (DATA !== 8'h00) begin $display("[TB] FAIL rstmid_data: got %h expected 00", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL rstmid_valid: got %b expected 0", VALID); missCount++; end
      waitTicks(8 + 48 + 16);
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL rstmid_no_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (BUSY !== 1'b0) begin $display("[TB] FAIL rstmid_idle: got %b expected 0", BUSY); missCount++; end
      vecCount++; if (ferrPulses != base) begin $display("[TB] FAIL rstmid_no_ferr: got %0d pulses expected 0", ferrPulses - base); missCount++; end
      sendFrame(8'h0F);
      vecCount++; if (DATA !== 8'h0F) begin $display("[TB] FAIL rstmid_next_data: got %h expected 0f", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL rstmid_next_valid: got %b expected 1", VALID); missCount++; end
   endtask

   // Leaves 0x0F unacknowledged, then acks exactly on the stop-centre tick edge.
   task automatic test_ack_coincide();
      waitTicks(1);
      RX = 1'b0;
      waitTicks(16);
      driveBits(8'hA5);
      RX = 1'b1;
      waitTicks(8);
      vecCount++; if (DATA !== 8'h0F) begin $display("[TB] FAIL coin_pre_data: got %h expected 0f", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL coin_pre_valid: got %b expected 1", VALID); missCount++; end
      repeat (3) @(posedge CLK);
      #1;
      DATA_ACK = 1'b1;
      @(posedge CLK);
      #1;
      DATA_ACK = 1'b0;
      vecCount++; if (DATA !== 8'hA5) begin $display("[TB] FAIL coin_data: got %h expected a5", DATA); missCount++; end
      vecCount++; if (VALID !== 1'b1) begin $display("[TB] FAIL coin_valid: got %b expected 1", VALID); missCount++; end
      vecCount++; if (OVERRUN !== 1'b0) begin $display("[TB] FAIL coin_overrun: got %b expected 0", OVERRUN); missCount++; end
      waitTicks(8);
      pulseAck();
      pulseAck();
      vecCount++; if (VALID !== 1'b0) begin $display("[TB] FAIL coin_idle_ack_valid: got %b expected 0", VALID); missCount++; end
      vecCount++; if (DATA !== 8'hA5) begin $display("[TB] FAIL coin_idle_ack_data: got %h expected a5", DATA); missCount++; end
   endtask

   initial begin
      RST      = 1'b1;
      RX       = 1'b1;
      DATA_ACK = 1'b0;
      test_reset();
      test_frame_55();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_reset_midframe();
      test_ack_coincide();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
